// File: rtl/uart_rx_pkg.sv
// UART shared definitions: FSM state encodings and default frame timing.
// Used by both the receiver and the matching transmitter.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int BPS_MAX_DEF = 5208;
  localparam int BIT_MAX_DEF = 8;

  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync_edge.sv
// Two-flop synchronizer followed by a registered falling-edge detector.
// Generic: usable for any asynchronous single-bit input.
module sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rx_s,
  output logic fall
);

  logic meta;
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      rx_s <= RST_VAL;
      prev <= RST_VAL;
      fall <= 1'b0;
    end else begin
      meta <= async_in;
      rx_s <= meta;
      prev <= rx_s;
      fall <= prev & ~rx_s;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start-bit validation at mid bit, LSB-first data,
// stop-bit check with one-cycle rx_valid / frame_err pulses.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int BPS_MAX = BPS_MAX_DEF,
  parameter int BIT_MAX = BIT_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  output logic [BIT_MAX-1:0] rx_data,
  output logic               rx_valid,
  output logic               frame_err,
  output logic               busy
);

  localparam int CW = cnt_width(BPS_MAX);
  localparam int BW = cnt_width(BIT_MAX + 1);

  localparam logic [CW-1:0] BPS_END = CW'(BPS_MAX - 1);
  localparam logic [CW-1:0] BPS_MID = CW'(BPS_MAX / 2 - 1);
  localparam logic [BW-1:0] BIT_END = BW'(BIT_MAX - 1);

  uart_state_t        state;
  logic [CW-1:0]      bps_cnt;
  logic [BW-1:0]      bit_cnt;
  logic [BIT_MAX-1:0] shift_reg;
  logic               rx_s;
  logic               fall;

  sync_edge #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (rx),
    .rx_s     (rx_s),
    .fall     (fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bps_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          bps_cnt <= '0;
          bit_cnt <= '0;
          if (fall) begin
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (bps_cnt == BPS_MID) begin
            bps_cnt <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            bps_cnt <= bps_cnt + CW'(1);
          end
        end
        DATA: begin
          if (bps_cnt == BPS_END) begin
            bps_cnt <= '0;
            for (int i = 0; i < BIT_MAX; i++) begin
              if (bit_cnt == BW'(i)) shift_reg[i] <= rx_s;
            end
            if (bit_cnt == BIT_END) begin
              bit_cnt <= '0;
              state   <= STOP;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else begin
            bps_cnt <= bps_cnt + CW'(1);
          end
        end
        STOP: begin
          if (bps_cnt == BPS_END) begin
            bps_cnt <= '0;
            state   <= IDLE;
            busy    <= 1'b0;
            // Leaving at mid stop bit gives half a bit of slack
            // for the next start edge.
            if (rx_s) begin
              rx_data  <= shift_reg;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            bps_cnt <= bps_cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 16 clocks per bit.
// Each task drives one scenario and checks its own results.
module tb_uart_rx;

  localparam int BPS = 16;
  localparam int BITS = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            rx  = 1'b1;
  logic [BITS-1:0] rx_data;
  logic            rx_valid;
  logic            frame_err;
  logic            busy;

  int compared = 0;
  int mismatched = 0;

  int cyc = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int valid_cyc = 0;
  int t_start = 0;
  logic [7:0] hist[$];

  int jdur[10] = '{14, 18, 17, 15, 18, 14, 16, 16, 16, 16};

  uart_rx #(
    .BPS_MAX (BPS),
    .BIT_MAX (BITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt++;
      valid_cyc = cyc;
      hist.push_back(rx_data);
    end
    if (frame_err) err_cnt++;
    if (rx_valid && frame_err) both_cnt++;
  end

  // Callers are always at posedge+#1 on entry and exit.
  task automatic send_frame(input logic [7:0] d,
                            input logic stop,
                            input bit jit);
    logic [9:0] bits;
    int dur;
    bits = {stop, d, 1'b0};
    t_start = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      dur = jit ? jdur[i] : BPS;
      repeat (dur) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if ({rx_valid, frame_err, busy} !== 3'b000) begin
      mismatched++;
      $display("FAIL reset_flags got=%b want=000",
               {rx_valid, frame_err, busy});
    end
    compared++;
    if (rx_data !== 8'h00) begin
      mismatched++;
      $display("FAIL reset_data got=%h want=00", rx_data);
    end
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL idle_busy got=%b want=0", busy);
    end
  endtask

  task automatic test_frame_a5;
    int v0, e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    send_frame(8'hA5, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    compared++;
    if (valid_cnt - v0 !== 1) begin
      mismatched++;
      $display("FAIL a5_valid_cycles got=%0d want=1", valid_cnt - v0);
    end
    compared++;
    if (rx_data !== 8'hA5) begin
      mismatched++;
      $display("FAIL a5_data got=%h want=a5", rx_data);
    end
    compared++;
    if (valid_cyc - t_start !== 156) begin
      mismatched++;
      $display("FAIL a5_latency got=%0d want=156", valid_cyc - t_start);
    end
    compared++;
    if (err_cnt - e0 !== 0) begin
      mismatched++;
      $display("FAIL a5_frame_err got=%0d want=0", err_cnt - e0);
    end
  endtask

  task automatic test_back_to_back;
    int v0, n0;
    v0 = valid_cnt;
    n0 = hist.size();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    compared++;
    if (valid_cnt - v0 !== 2) begin
      mismatched++;
      $display("FAIL b2b_count got=%0d want=2", valid_cnt - v0);
    end
    compared++;
    if (hist.size() < n0 + 2) begin
      mismatched++;
      $display("FAIL b2b_hist got=%0d want=%0d", hist.size(), n0 + 2);
    end else begin
      compared++;
      if (hist[n0] !== 8'h00) begin
        mismatched++;
        $display("FAIL b2b_first got=%h want=00", hist[n0]);
      end
      compared++;
      if (hist[n0+1] !== 8'hFF) begin
        mismatched++;
        $display("FAIL b2b_second got=%h want=ff", hist[n0+1]);
      end
    end
  endtask

  task automatic test_glitch;
    int v0, e0, n;
    v0 = valid_cnt;
    e0 = err_cnt;
    rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (busy !== 1'b1) begin
      mismatched++;
      $display("FAIL glitch_busy_rise got=%b want=1", busy);
    end
    n = 0;
    while (busy === 1'b1 && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL glitch_busy_fall got=%b want=0 after %0d", busy, n);
    end
    repeat (20) @(posedge clk);
    #1;
    compared++;
    if ((valid_cnt - v0) + (err_cnt - e0) !== 0) begin
      mismatched++;
      $display("FAIL glitch_pulses got=%0d want=0",
               (valid_cnt - v0) + (err_cnt - e0));
    end
  endtask

  task automatic test_frame_err;
    int v0, e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    compared++;
    if (err_cnt - e0 !== 1) begin
      mismatched++;
      $display("FAIL ferr_cycles got=%0d want=1", err_cnt - e0);
    end
    compared++;
    if (valid_cnt - v0 !== 0) begin
      mismatched++;
      $display("FAIL ferr_valid got=%0d want=0", valid_cnt - v0);
    end
    compared++;
    if (rx_data !== 8'hFF) begin
      mismatched++;
      $display("FAIL ferr_data_hold got=%h want=ff", rx_data);
    end
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL ferr_idle got=%b want=0", busy);
    end
  endtask

  task automatic test_reset_mid_frame;
    int v0, e0;
    logic [9:0] bits;
    v0 = valid_cnt;
    e0 = err_cnt;
    bits = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rx = bits[i];
      repeat (BPS) @(posedge clk);
      #1;
    end
    rx = bits[5];
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if ({rx_valid, frame_err, busy} !== 3'b000) begin
      mismatched++;
      $display("FAIL midrst_flags got=%b want=000",
               {rx_valid, frame_err, busy});
    end
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    compared++;
    if ((valid_cnt - v0) + (err_cnt - e0) !== 0) begin
      mismatched++;
      $display("FAIL midrst_pulses got=%0d want=0",
               (valid_cnt - v0) + (err_cnt - e0));
    end
    send_frame(8'h81, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    compared++;
    if (valid_cnt - v0 !== 1) begin
      mismatched++;
      $display("FAIL midrst_valid got=%0d want=1", valid_cnt - v0);
    end
    compared++;
    if (rx_data !== 8'h81) begin
      mismatched++;
      $display("FAIL midrst_data got=%h want=81", rx_data);
    end
  endtask

  task automatic test_jitter;
    int v0;
    v0 = valid_cnt;
    send_frame(8'h5A, 1'b1, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    compared++;
    if (valid_cnt - v0 !== 1) begin
      mismatched++;
      $display("FAIL jit_valid got=%0d want=1", valid_cnt - v0);
    end
    compared++;
    if (rx_data !== 8'h5A) begin
      mismatched++;
      $display("FAIL jit_data got=%h want=5a", rx_data);
    end
  endtask

  task automatic test_exclusive;
    compared++;
    if (both_cnt !== 0) begin
      mismatched++;
      $display("FAIL pulse_overlap got=%0d want=0", both_cnt);
    end
  endtask

  initial begin
    test_reset;
    test_frame_a5;
    test_back_to_back;
    test_glitch;
    test_frame_err;
    test_reset_mid_frame;
    test_jitter;
    test_exclusive;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter BPS_MAX, default 5208: clock cycles per bit period (9600 baud at 50 MHz).
REQ-002 The block SHALL have parameter BIT_MAX, default 8: data bits per frame.
REQ-003 The block SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port rx, input, 1 bit: serial line, asynchronous to clk; idles high.
REQ-006 The block SHALL have port rx_data, output, BIT_MAX bits: last correctly framed byte.
REQ-007 The block SHALL have port rx_valid, output, 1 bit: one-cycle pulse when rx_data updates.
REQ-008 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse when the stop bit samples low.
REQ-009 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-010 The block SHALL receive the frame format: 1 start bit (low), BIT_MAX data bits LSB first, 1 stop bit (high), no parity.
REQ-011 The block SHALL pass rx through a 2-flop synchronizer (reset value 1) before any use; the synchronized value is rx_s.
REQ-012 The block SHALL detect a start edge as a high-to-low transition on rx_s, from a 1-cycle-delayed copy of rx_s with reset value 1.
REQ-013 The block SHALL implement the FSM states IDLE, START, DATA, STOP, with a single 1-hot or binary state register.
REQ-014 In IDLE, the block SHALL hold bps_cnt=0 and bit_cnt=0, and SHALL move to START on a detected start edge.
REQ-015 In START, bps_cnt SHALL count up; at bps_cnt==BPS_MAX/2-1 (integer division, mid start bit):
  - rx_s==0: the block SHALL clear bps_cnt and go to DATA;
  - rx_s==1: this is a glitch; the block SHALL go to IDLE with no output pulse.
REQ-016 In DATA, bps_cnt SHALL wrap at BPS_MAX-1.
REQ-017 At each wrap in DATA, the block SHALL shift rx_s into shift register bit bit_cnt and increment bit_cnt.
REQ-018 After the BIT_MAX-th sample in DATA, the block SHALL clear bit_cnt and go to STOP.
REQ-019 In STOP, at bps_cnt==BPS_MAX-1 (mid stop bit), with rx_s==1:
  - rx_data SHALL be loaded from the shift register;
  - rx_valid SHALL be 1 for exactly the next cycle;
  - the block SHALL go to IDLE.
REQ-020 In STOP, at bps_cnt==BPS_MAX-1, with rx_s==0:
  - frame_err SHALL be 1 for exactly the next cycle;
  - rx_data SHALL be unchanged;
  - the block SHALL go to IDLE.
REQ-021 rx_valid and frame_err SHALL never both be high in the same cycle.
REQ-022 rx_data SHALL hold its value until the next valid frame.
REQ-023 Because the block returns to IDLE at mid stop bit, a start edge arriving half a bit later SHALL be accepted, so back-to-back frames lose no data.
REQ-024 After a frame_err, the block SHALL return to IDLE.
REQ-025 After a frame_err, the block SHALL not detect a new start until rx_s has been seen high and then falls (break condition tolerated).
REQ-026 Latency from the rx pin falling edge to rx_valid SHALL be BPS_MAX/2 + (BIT_MAX+1)*BPS_MAX + 4 cycles (±0; includes synchronizer and edge detect).
REQ-027 bps_cnt SHALL be wide enough for BPS_MAX-1, computed with $clog2 and never narrower.
REQ-028 bit_cnt SHALL be wide enough for BIT_MAX.
REQ-029 The block SHALL function for BPS_MAX>=4.

Reset
REQ-030 While rst is high, the following SHALL hold their reset values:
  - state=IDLE, bps_cnt=0, bit_cnt=0;
  - shift register=0, rx_data=0;
  - rx_valid=0, frame_err=0, busy=0;
  - synchronizer and edge flops=1.
REQ-031 Reset asserted mid-frame SHALL abandon the frame with no rx_valid or frame_err pulse.
REQ-032 After reset release, the first start edge SHALL be received normally.

Structure
REQ-033 A shared package SHALL hold the state encodings (IDLE=0, START=1, DATA=2, STOP=3) and the default BPS_MAX/BIT_MAX constants used by both uart_rx and the transmitter.
REQ-034 The 2-flop synchronizer plus edge detector SHALL be one sub-module, sync_edge (outputs rx_s, fall).
REQ-035 The sync_edge sub-module SHALL be reusable for other asynchronous inputs.

Verification (BPS_MAX=16, BIT_MAX=8; stimulus driven by a model or by the existing transmitter)
REQ-036 Frame 0xA5, correct stop bit -> rx_data=0xA5, rx_valid high 1 cycle at 8+9*16+4=156 cycles after the falling edge, frame_err never high.
REQ-037 Frames 0x00 then 0xFF back-to-back, no idle gap -> two rx_valid pulses with rx_data 0x00 then 0xFF.
REQ-038 rx low for 3 cycles then high -> START aborts at the mid check, no pulses, busy returns 0 within 8 cycles.
REQ-039 Frame 0x3C with stop bit driven low -> frame_err 1 cycle, rx_valid 0, rx_data keeps its previous value.
REQ-040 rst asserted during DATA bit 4 of frame 0x55, released, then frame 0x81 sent -> no pulse for 0x55, rx_data=0x81 with rx_valid.
REQ-041 Frame 0x5A with rx edges jittered ±2 cycles -> rx_data=0x5A received correctly.
